// File: rtl/transpose_pkg.sv
// Shared constants and lane-index helpers for the diagonal-storage transpose buffer.
package transpose_pkg;

   localparam logic MODE_TRANSPOSE = 1'b0;
   localparam logic MODE_PASS      = 1'b1;

   localparam bit ROT_LEFT  = 1'b0;
   localparam bit ROT_RIGHT = 1'b1;

   // n is the lane count and is always a power of two.
   function automatic int unsigned rot_idx(int unsigned i, int unsigned s, int unsigned n);
      return (i + s) & (n - 1);
   endfunction

endpackage

// File: rtl/transpose_rotate_buf_if.sv
// Row-in / row-out valid-ready bundle of the transpose buffer.
interface transpose_rotate_buf_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_PE     = 8
);
   localparam int unsigned ROW_W = DATA_WIDTH * NUM_PE;

   logic             in_valid;
   logic             in_ready;
   logic [ROW_W-1:0] in_row;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [ROW_W-1:0] out_row;
   logic             out_last;

   modport master (
      output in_valid, in_row, in_mode, out_ready,
      input  in_ready, out_valid, out_row, out_last
   );

   modport slave (
      input  in_valid, in_row, in_mode, out_ready,
      output in_ready, out_valid, out_row, out_last
   );

endinterface

// File: rtl/lane_rotator.sv
// Combinational rotation of a packed row by a runtime element count.
// ROT_LEFT moves element j to lane j+shift; ROT_RIGHT moves lane j+shift to element j.
module lane_rotator
   import transpose_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_PE     = 8,
   parameter bit          DIR        = ROT_LEFT
) (
   input  logic [DATA_WIDTH*NUM_PE-1:0] row_i,
   input  logic [$clog2(NUM_PE)-1:0]    shift_i,
   output logic [DATA_WIDTH*NUM_PE-1:0] row_o
);
   localparam int unsigned IdxW = $clog2(NUM_PE);

   logic [IdxW-1:0] src_shift;

   always_comb begin
      // A left rotation by s equals a right rotation by NUM_PE - s.
      src_shift = (DIR == ROT_RIGHT) ? shift_i : IdxW'(NUM_PE - 32'(shift_i));
      row_o = '0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         row_o[k*DATA_WIDTH +: DATA_WIDTH] =
            row_i[rot_idx(k, 32'(src_shift), NUM_PE)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: rtl/transpose_rotate_buf.sv
// Ping-pong NUM_PE x NUM_PE transpose buffer using diagonal storage: each lane bank is
// touched once per row on both sides, so rotation replaces a full crossbar.
module transpose_rotate_buf
   import transpose_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_PE     = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   transpose_rotate_buf_if.slave bus
);
   localparam int unsigned     ROW_W  = DATA_WIDTH * NUM_PE;
   localparam int unsigned     IdxW   = $clog2(NUM_PE);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_PE - 1);

   typedef logic [DATA_WIDTH-1:0] elem_t;

   elem_t           mem_q [2][NUM_PE][NUM_PE];
   elem_t           mem_d [2][NUM_PE][NUM_PE];
   logic [1:0]      full_q, full_d;
   logic [1:0]      mode_q, mode_d;
   logic            wb_q, wb_d, rb_q, rb_d;
   logic [IdxW-1:0] wr_q, wr_d, rc_q, rc_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic [ROW_W-1:0] out_row_q, out_row_d;

   logic [ROW_W-1:0] wr_row, rd_lanes, rd_row;
   logic [IdxW-1:0]  rd_addr [NUM_PE];
   logic             accept, load;

   assign bus.in_ready  = ~full_q[wb_q];
   assign bus.out_valid = out_valid_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_last  = out_last_q;

   assign accept = bus.in_valid & ~full_q[wb_q];
   assign load   = full_q[rb_q] & (~out_valid_q | bus.out_ready);

   lane_rotator #(
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_PE    (NUM_PE),
      .DIR       (ROT_LEFT)
   ) u_wr_rot (
      .row_i  (bus.in_row),
      .shift_i(wr_q),
      .row_o  (wr_row)
   );

   // Transpose walks the diagonal of column rc; pass reads straight across row rc.
   always_comb begin
      rd_lanes = '0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         rd_addr[k] = (mode_q[rb_q] == MODE_PASS) ? rc_q : IdxW'(k) - rc_q;
         rd_lanes[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rb_q][k][rd_addr[k]];
      end
   end

   lane_rotator #(
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_PE    (NUM_PE),
      .DIR       (ROT_RIGHT)
   ) u_rd_rot (
      .row_i  (rd_lanes),
      .shift_i(rc_q),
      .row_o  (rd_row)
   );

   always_comb begin
      mem_d       = mem_q;
      full_d      = full_q;
      mode_d      = mode_q;
      wb_d        = wb_q;
      wr_d        = wr_q;
      rb_d        = rb_q;
      rc_d        = rc_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_row_d   = out_row_q;

      if (accept) begin
         for (int unsigned k = 0; k < NUM_PE; k++) begin
            mem_d[wb_q][k][wr_q] = wr_row[k*DATA_WIDTH +: DATA_WIDTH];
         end
         if (wr_q == '0) mode_d[wb_q] = bus.in_mode;
         wr_d = wr_q + IdxW'(1);
         if (wr_q == IdxMax) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
         end
      end

      // Never the same bank as the write side: accept needs !full, load needs full.
      if (load) begin
         out_valid_d = 1'b1;
         out_row_d   = rd_row;
         out_last_d  = (rc_q == IdxMax);
         rc_d        = rc_q + IdxW'(1);
         if (rc_q == IdxMax) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q       <= '{default: '0};
         full_q      <= '0;
         mode_q      <= '0;
         wb_q        <= 1'b0;
         wr_q        <= '0;
         rb_q        <= 1'b0;
         rc_q        <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_row_q   <= '0;
      end else begin
         mem_q       <= mem_d;
         full_q      <= full_d;
         mode_q      <= mode_d;
         wb_q        <= wb_d;
         wr_q        <= wr_d;
         rb_q        <= rb_d;
         rc_q        <= rc_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_row_q   <= out_row_d;
      end
   end

endmodule

// File: doc/transpose_rotate_buf.md
# transpose_rotate_buf

Ping-pong NUM_PE×NUM_PE element transpose buffer for the matrix-transpose path. It uses diagonal (rotation-based) storage, so every lane bank is written and read exactly once per cycle with no crossbar. Rows stream in over a valid/ready handshake, and columns, or the original rows in pass mode, stream out. One bank fills while the other drains, which gives full throughput.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per element
- NUM_PE, 8, lanes per row and rows per block; power of two, ≥2
- ROW_W, DATA_WIDTH*NUM_PE (derived), row bus width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_row valid
- in_ready  out  1  buffer can accept a row
- in_row  in  ROW_W  element j at bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
- in_mode  in  1  0 = transpose, 1 = pass; sampled on a block's first accepted row only
- out_valid  out  1  out_row valid
- out_ready  in  1  consumer accepts out_row
- out_row  out  ROW_W  column c (transpose) or row r (pass); same lane packing
- out_last  out  1  final row of a block; qualified by out_valid

## Operation
- Storage: 2 banks × NUM_PE lanes × NUM_PE entries. Per-bank state: full flag, latched mode.
- Write pointer wb and row counter wr (log2 NUM_PE bits).
  - Accept = in_valid && in_ready.
  - Row r element j is written to lane (j+r) mod NUM_PE, address r. This is a left rotation by r elements.
  - On accept with wr = NUM_PE-1: set full[wb], toggle wb, clear wr.
- Read pointer rb and column counter rc.
  - Transpose mode, column c: lane k reads address (k−c) mod NUM_PE. out element i = lane (i+c) mod NUM_PE, a right rotation by c.
  - Pass mode, row r: every lane reads address r. out element i = lane (i+r) mod NUM_PE.
- Output register: loads the next row from bank rb when full[rb] && (!out_valid || out_ready).
  - out_last = (rc == NUM_PE-1) at load.
  - On loading rc = NUM_PE-1: clear full[rb], toggle rb, clear rc.
- in_ready = !full[wb].
- All index arithmetic is modulo NUM_PE by truncation to log2 NUM_PE bits.

## Timing
- Reset (asynchronous assert): wb=rb=0, wr=rc=0, full=0, out_valid=0, out_row=0, out_last=0, in_ready=1 (follows full). A partial block is discarded.
- Latency: last row of a block accepted at edge E, full set at E. First output loaded at E+1, so out_valid=1 after E+1.
- Throughput: one row per cycle in, one per cycle out, sustained across blocks with out_ready=1.
- Backpressure: while out_valid && !out_ready, out_row, out_last and rc hold.
- Bank freed at the edge loading its last row. A write into that bank is allowed from the next cycle (no same-edge bypass).
- Both banks full: in_ready=0 until a bank frees.
- Fill and drain of different banks in the same cycle are independent.
- in_mode is ignored on rows 1..NUM_PE-1 of a block.

## Structure
- Package transpose_pkg holds:
  - the lane-index helpers: function rot_idx(i, s) returning (i+s) mod NUM_PE
  - the mode encoding constants MODE_TRANSPOSE=0, MODE_PASS=1
- Sub-module lane_rotator (combinational):
  - parameters DATA_WIDTH, NUM_PE, DIR
  - rotates a row by a runtime element count
  - instantiated twice: write side DIR=left, read side DIR=right
- Top level holds the counters, flags, bank storage and output register.

## Test plan
All scenarios use NUM_PE=8, DATA_WIDTH=16, and in_row[r][j] = 16r+j unless stated.
- Single transpose block, out_ready=1 → out_valid rises 1 edge after the 8th accept. Column 0 = {0,16,…,112}, column 7 = {7,23,…,119}. out_last only on column 7.
- Pass mode block → outputs equal the input rows in order. out_last on row 7.
- Random out_ready (30% high) → out_row stable during stalls. All 8 columns delivered exactly once, in order.
- Three back-to-back blocks, out_ready=1 → in_ready never drops. 24 outputs arrive contiguously. Modes alternate transpose/pass/transpose and each block's mode is honoured.
- out_ready=0, feed 17 rows → in_ready=0 after the 16th accept, and the 17th row waits. Raising out_ready frees bank 0 after 8 loads, and the 17th row is accepted the cycle after.
- rst_n pulsed low after 3 rows of a block → out_valid=0, out_row=0 immediately. No output until 8 fresh rows follow. Repeat with NUM_PE=4, DATA_WIDTH=3, values mod 8.
